frogg_move_queue: RTL and testbench

Input-side companion to the Frogg game core: sits between the four debounced push-button outputs and the game logic. Converts button presses into single move commands, queues them in a small FIFO and releases at most one move per video frame, synchronized to the start of vertical blanking. Also generates held-button auto-repeat and a four-button "start" chord pulse.

---
 rtl/frogg_move_queue_if.sv | 32 +++
 rtl/frogg_move_queue.sv | 171 +++++++++++++++++
 tb/tb_frogg_move_queue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frogg_move_queue_if.sv
// Signal bundle between the Frogg move queue and its surroundings: VSync and
// button inputs in, move/start pulses and queue status out.
interface frogg_move_queue_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             i_VSync;
  logic             i_Switch_1;
  logic             i_Switch_2;
  logic             i_Switch_3;
  logic             i_Switch_4;
  logic             o_Move_Up;
  logic             o_Move_Dn;
  logic             o_Move_Lt;
  logic             o_Move_Rt;
  logic             o_Game_Start;
  logic [CNT_W-1:0] o_Fifo_Count;
  logic             o_Overflow;

  modport slave (
    input  i_VSync, i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_Move_Up, o_Move_Dn, o_Move_Lt, o_Move_Rt,
    output o_Game_Start, o_Fifo_Count, o_Overflow
  );

  modport master (
    output i_VSync, i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_Move_Up, o_Move_Dn, o_Move_Lt, o_Move_Rt,
    input  o_Game_Start, o_Fifo_Count, o_Overflow
  );
endinterface

// File: rtl/frogg_move_queue.sv
// Turns button presses and held-button auto-repeat into queued moves, releasing
// at most one move per frame at the start of vertical blanking; also detects the start chord.
module frogg_move_queue #(
  parameter int REPEAT_DELAY_FRAMES = 20,
  parameter int REPEAT_RATE_FRAMES  = 6,
  parameter int CHORD_FRAMES        = 30,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  frogg_move_queue_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES);
  localparam int KW = $clog2(CHORD_FRAMES + 1);

  logic          vsync_q;
  logic [3:0]    sw_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [KW-1:0] chord_cnt_q, chord_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    move_q, move_d;
  logic          start_q, start_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    mem [FIFO_DEPTH];

  logic [3:0]    sw;
  logic [3:0]    press;
  logic          tick;
  logic          all_held;
  logic          one_held;
  logic          repeat_fire;
  logic          chord_fire;
  logic          wr_en;
  logic [1:0]    wr_code;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;

  // Bit order doubles as the move code and the priority order (up wins).
  function automatic logic [1:0] enc_low(input logic [3:0] v);
    logic [1:0] r;
    if (v[0])      r = 2'd0;
    else if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  assign sw       = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};
  assign tick     = ~bus.i_VSync & vsync_q;
  assign press    = sw & ~sw_q;
  assign all_held = &sw;
  assign one_held = (sw != 4'b0) && ((sw & (sw - 4'd1)) == 4'b0);

  // After the first repeat the counter folds back to the delay value, so
  // every REPEAT_RATE_FRAMES further ticks land on the same compare.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    repeat_fire = 1'b0;
    if ((sw != sw_q) || !one_held) begin
      hold_cnt_d = '0;
    end else if (tick) begin
      if (hold_cnt_q == HW'(REPEAT_DELAY_FRAMES + REPEAT_RATE_FRAMES - 1)) begin
        hold_cnt_d  = HW'(REPEAT_DELAY_FRAMES);
        repeat_fire = 1'b1;
      end else begin
        hold_cnt_d  = hold_cnt_q + HW'(1);
        repeat_fire = (hold_cnt_q == HW'(REPEAT_DELAY_FRAMES - 1));
      end
    end
  end

  // Saturating at CHORD_FRAMES keeps the chord from re-firing until a release.
  always_comb begin
    chord_cnt_d = chord_cnt_q;
    chord_fire  = 1'b0;
    if (!all_held) begin
      chord_cnt_d = '0;
    end else if (tick && (chord_cnt_q != KW'(CHORD_FRAMES))) begin
      chord_cnt_d = chord_cnt_q + KW'(1);
      chord_fire  = (chord_cnt_q == KW'(CHORD_FRAMES - 1));
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_code = 2'd0;
    if (!all_held) begin
      if (press != 4'b0) begin
        wr_en   = 1'b1;
        wr_code = enc_low(press);
      end else if (repeat_fire) begin
        wr_en   = 1'b1;
        wr_code = enc_low(sw);
      end
    end
  end

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = tick && (count_q != '0);
  assign push = wr_en && !chord_fire && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    move_d   = 4'b0;
    start_d  = chord_fire;
    ovf_d    = ovf_q | drop;
    if (chord_fire) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        move_d   = 4'b0001 << mem[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr_q] <= wr_code;
  end

  // Switch copies reset high so a button held through reset is not a press.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vsync_q     <= 1'b0;
      sw_q        <= 4'hF;
      hold_cnt_q  <= '0;
      chord_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      move_q      <= 4'b0;
      start_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vsync_q     <= bus.i_VSync;
      sw_q        <= sw;
      hold_cnt_q  <= hold_cnt_d;
      chord_cnt_q <= chord_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      move_q      <= move_d;
      start_q     <= start_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.o_Move_Up    = move_q[0];
  assign bus.o_Move_Dn    = move_q[1];
  assign bus.o_Move_Lt    = move_q[2];
  assign bus.o_Move_Rt    = move_q[3];
  assign bus.o_Game_Start = start_q;
  assign bus.o_Fifo_Count = count_q;
  assign bus.o_Overflow   = ovf_q;
endmodule

// File: tb/tb_frogg_move_queue.sv
// Randomized and directed bench for frogg_move_queue with a queue-based reference
// model; expected moves and start pulses go to a scoreboard checked by a monitor.
module tb_frogg_move_queue;
  localparam int D     = 3;
  localparam int R     = 2;
  localparam int CH    = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'h0;
  logic       vs  = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frogg_move_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();

  assign bus.i_VSync    = vs;
  assign bus.i_Switch_1 = sw[0];
  assign bus.i_Switch_2 = sw[1];
  assign bus.i_Switch_3 = sw[2];
  assign bus.i_Switch_4 = sw[3];

  frogg_move_queue #(
    .REPEAT_DELAY_FRAMES(D),
    .REPEAT_RATE_FRAMES (R),
    .CHORD_FRAMES       (CH),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [1:0] m_q[$];
  logic [1:0] exp_q[$];
  int         exp_start;
  logic       m_ovf;
  logic [3:0] m_prev_sw;
  logic       m_prev_vs;
  int         m_hold;
  int         m_chord;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    exp_start = 0;
    m_ovf     = 1'b0;
    m_prev_sw = 4'hF;
    m_prev_vs = 1'b0;
    m_hold    = 0;
    m_chord   = 0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [3:0] pr;
    logic [1:0] code;
    bit tick, all4, pop, fire, rep, wr;
    s    = sw;
    pr   = s & ~m_prev_sw;
    tick = !vs && m_prev_vs;
    all4 = (s == 4'hF);
    pop  = tick && (m_q.size() > 0);
    fire = 1'b0;
    rep  = 1'b0;
    wr   = 1'b0;
    code = 2'd0;
    if (!all4) m_chord = 0;
    else if (tick) begin
      m_chord++;
      fire = (m_chord == CH);
    end
    if ((s != m_prev_sw) || ($countones(s) != 1)) m_hold = 0;
    else if (tick) begin
      m_hold++;
      rep = (m_hold == D) || (m_hold > D && ((m_hold - D) % R) == 0);
    end
    if (!all4) begin
      if (pr != 4'b0) begin wr = 1'b1; code = low_idx(pr); end
      else if (rep)   begin wr = 1'b1; code = low_idx(s);  end
    end
    if (fire) begin
      m_q.delete();
      exp_start++;
    end else begin
      if (pop) exp_q.push_back(m_q.pop_front());
      if (wr) begin
        if (m_q.size() < DEPTH) m_q.push_back(code);
        else m_ovf = 1'b1;
      end
    end
    m_prev_sw = s;
    m_prev_vs = vs;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int seen[4] = '{0, 0, 0, 0};
  int starts_seen = 0;

  function automatic logic [3:0] dut_moves();
    return {bus.o_Move_Rt, bus.o_Move_Lt, bus.o_Move_Dn, bus.o_Move_Up};
  endfunction

  initial begin
    logic [3:0] mv;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      mv = dut_moves();
      chk("move_onehot", ($countones(mv) > 1) ? 1 : 0, 0);
      if (mv != 4'b0) begin
        seen[low_idx(mv)]++;
        if (exp_q.size() == 0) begin
          chk("move_spurious", int'(mv), 0);
        end else begin
          e = exp_q.pop_front();
          chk("move_code", int'(mv), 1 << e);
          $display("t=%0t move dir=%0d count=%0d", $time, e, bus.o_Fifo_Count);
        end
      end else if (exp_q.size() != 0) begin
        chk("move_missing", 0, 1 << exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (bus.o_Game_Start) begin
        starts_seen++;
        chk("start_spurious", 1, (exp_start > 0) ? 1 : 0);
        if (exp_start > 0) exp_start--;
        $display("t=%0t game start", $time);
      end else if (exp_start != 0) begin
        chk("start_missing", 0, 1);
        exp_start = 0;
      end
      chk("fifo_count", int'(bus.o_Fifo_Count), m_q.size());
      chk("overflow", int'(bus.o_Overflow), int'(m_ovf));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(input logic [3:0] v);
    @(negedge clk);
    sw = v;
  endtask

  task automatic press(input logic [3:0] v);
    set_sw(v);
    set_sw(4'h0);
  endtask

  task automatic tick();
    @(negedge clk) vs = 1'b0;
    @(negedge clk) vs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int b0, b1, b2, b3, r;
    cyc(2);
    chk("rst_count", int'(bus.o_Fifo_Count), 0);
    chk("rst_moves", int'(dut_moves()), 0);
    chk("rst_ovf", int'(bus.o_Overflow), 0);
    chk("rst_start", int'(bus.o_Game_Start), 0);
    @(negedge clk) rst = 1'b0;
    cyc(2);

    // single move
    b0 = seen[0];
    press(4'h1);
    chk("single_count1", int'(bus.o_Fifo_Count), 1);
    tick();
    chk("single_count0", int'(bus.o_Fifo_Count), 0);
    chk("single_up", seen[0] - b0, 1);

    // queue order and overflow
    press(4'h8); press(4'h4); press(4'h2); press(4'h1); press(4'h8);
    cyc(1);
    chk("ovf_count", int'(bus.o_Fifo_Count), 4);
    chk("ovf_flag", int'(bus.o_Overflow), 1);
    repeat (4) tick();
    chk("ovf_drained", int'(bus.o_Fifo_Count), 0);

    // auto-repeat on a held left button
    b2 = seen[2];
    set_sw(4'h4);
    repeat (9) tick();
    set_sw(4'h0);
    repeat (2) tick();
    chk("repeat_lt", seen[2] - b2, 5);

    // simultaneous up + right
    b0 = seen[0]; b3 = seen[3];
    press(4'h9);
    chk("simul_count", int'(bus.o_Fifo_Count), 1);
    tick();
    chk("simul_up", seen[0] - b0, 1);
    chk("simul_rt", seen[3] - b3, 0);

    // chord with a full queue; flush beats the pop on the third tick
    press(4'h1); press(4'h2); press(4'h4); press(4'h8);
    chk("chord_q4", int'(bus.o_Fifo_Count), 4);
    b0 = seen[0] + seen[1] + seen[2] + seen[3];
    b1 = starts_seen;
    set_sw(4'hF);
    repeat (2) tick();
    chk("chord_q2", int'(bus.o_Fifo_Count), 2);
    tick();
    chk("chord_flush", int'(bus.o_Fifo_Count), 0);
    chk("chord_moves", seen[0] + seen[1] + seen[2] + seen[3] - b0, 2);
    chk("chord_start1", starts_seen - b1, 1);
    repeat (3) tick();
    chk("chord_no_refire", starts_seen - b1, 1);
    set_sw(4'hE);
    cyc(2);
    set_sw(4'hF);
    repeat (3) tick();
    chk("chord_start2", starts_seen - b1, 2);
    set_sw(4'h0);
    cyc(2);

    // reset while a move pulse is on the outputs
    press(4'h2);
    @(negedge clk) vs = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_before_rst", int'(bus.o_Move_Dn), 1);
    #1 rst = 1'b1;
    #1;
    chk("pulse_aborted", int'(dut_moves()), 0);
    @(negedge clk) vs = 1'b1;
    @(negedge clk) rst = 1'b0;
    cyc(2);

    // reset with three queued and a tick pending
    press(4'h1); press(4'h2); press(4'h4);
    chk("rst_mid_q3", int'(bus.o_Fifo_Count), 3);
    @(negedge clk) vs = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_count", int'(bus.o_Fifo_Count), 0);
    chk("rst_mid_moves", int'(dut_moves()), 0);
    chk("rst_mid_ovf", int'(bus.o_Overflow), 0);
    sw = 4'h1;
    @(negedge clk) vs = 1'b1;
    cyc(2);
    @(negedge clk) rst = 1'b0;
    b0 = seen[0] + seen[1] + seen[2] + seen[3];
    repeat (2) tick();
    chk("rst_held_count", int'(bus.o_Fifo_Count), 0);
    chk("rst_held_moves", seen[0] + seen[1] + seen[2] + seen[3] - b0, 0);
    set_sw(4'h0);
    cyc(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      vs = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6)      sw = 4'b0001 << $urandom_range(0, 3);
        else if (r < 8) sw = 4'hF;
        else            sw = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end
    end
    sw = 4'h0;
    vs = 1'b1;
    cyc(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
